// File: rtl/ring_phase_monitor.sv
// Qualifies a 4-bit one-hot ring counter: decodes the phase, locks after a run of
// legal rotations, counts revolutions and latches integrity/sequence errors.
module ring_phase_monitor #(
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             q0,
  input  logic             q1,
  input  logic             q2,
  input  logic             q3,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_cnt,
  output logic             err_onehot,
  output logic             err_seq
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [1:0] hot_index(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic [3:0] q_p0, q_p1;
  state_t     state_r, state_nx;
  logic [3:0] lc_r, lc_nx, lc_inc;
  logic       s_hot, adv, hold, zero, badhot, jump;
  logic       tick_nx, set_onehot, set_seq;

  // Stage p0: current sample S; stage p1: previous sample P
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_p0 <= 4'b0000;
      q_p1 <= 4'b0000;
    end else begin
      q_p0 <= {q3, q2, q1, q0};
      q_p1 <= q_p0;
    end
  end

  assign s_hot  = is_onehot(q_p0);
  assign adv    = s_hot && (q_p0 == rotl(q_p1));
  assign hold   = s_hot && (q_p0 == q_p1);
  assign zero   = (q_p0 == 4'b0000);
  assign badhot = !zero && !s_hot;
  assign jump   = s_hot && !adv && !hold;
  assign lc_inc = lc_r + 4'd1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= HUNT;
      lc_r    <= 4'd0;
    end else begin
      state_r <= state_nx;
      lc_r    <= lc_nx;
    end
  end

  always_comb begin
    state_nx = state_r;
    lc_nx    = lc_r;
    case (state_r)
      HUNT: begin
        if (adv) begin
          if (lc_inc == LOCK_TGT) begin
            state_nx = LOCKED;
            lc_nx    = 4'd0;
          end else begin
            lc_nx = lc_inc;
          end
        end else if (!hold) begin
          lc_nx = 4'd0;
        end
      end
      LOCKED: begin
        lc_nx = 4'd0;
        if (zero || badhot || jump) state_nx = HUNT;
      end
      default: begin
        state_nx = HUNT;
        lc_nx    = 4'd0;
      end
    endcase
  end

  // The locking advance is evaluated in HUNT, so it can never tick
  always_comb begin
    tick_nx    = (state_r == LOCKED) && adv && (q_p1 == 4'b1000);
    set_onehot = (state_r == LOCKED) && badhot;
    set_seq    = (state_r == LOCKED) && jump;
  end

  // Stage p2: registered status and phase decode of S
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rev_tick    <= 1'b0;
      rev_cnt     <= '0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
      phase       <= 2'd0;
      phase_valid <= 1'b0;
    end else begin
      rev_tick    <= tick_nx;
      if (tick_nx) rev_cnt <= rev_cnt + REV_W'(1);
      err_onehot  <= set_onehot | (err_onehot & ~err_clr);
      err_seq     <= set_seq | (err_seq & ~err_clr);
      phase       <= hot_index(q_p0);
      phase_valid <= s_hot;
    end
  end

  assign locked = (state_r == LOCKED);

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor: a default instance plus a REV_W=2
// instance sharing the same ring stimulus for the counter wrap check.
module tb_ring_phase_monitor;

  logic       clk = 1'b0;
  logic       clr, q0, q1, q2, q3, err_clr;
  logic [1:0] phase, phase2;
  logic       phase_valid, locked, rev_tick, err_onehot, err_seq;
  logic       phase_valid2, locked2, rev_tick2, err_onehot2, err_seq2;
  logic [7:0] rev_cnt;
  logic [1:0] rev_cnt2;
  logic [3:0] last;
  int         n_cmp = 0;
  int         n_fail = 0;

  ring_phase_monitor #(.REV_W(8), .LOCK_CNT(4)) dut (
    .clk(clk), .clr(clr), .q0(q0), .q1(q1), .q2(q2), .q3(q3), .err_clr(err_clr),
    .phase(phase), .phase_valid(phase_valid), .locked(locked), .rev_tick(rev_tick),
    .rev_cnt(rev_cnt), .err_onehot(err_onehot), .err_seq(err_seq)
  );

  ring_phase_monitor #(.REV_W(2), .LOCK_CNT(4)) dut2 (
    .clk(clk), .clr(clr), .q0(q0), .q1(q1), .q2(q2), .q3(q3), .err_clr(err_clr),
    .phase(phase2), .phase_valid(phase_valid2), .locked(locked2), .rev_tick(rev_tick2),
    .rev_cnt(rev_cnt2), .err_onehot(err_onehot2), .err_seq(err_seq2)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] v);
    {q3, q2, q1, q0} = v;
    last = v;
    @(posedge clk);
    #1;
  endtask

  task automatic rotate(input int n);
    for (int i = 0; i < n; i++) drive({last[2:0], last[3]});
  endtask

  task automatic test_reset;
    clr = 1'b0; err_clr = 1'b0; {q3, q2, q1, q0} = 4'b0001;
    #23;
    n_cmp++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_cmp++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL reset_phase_valid: got %0b want 0", phase_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", locked); end
    n_cmp++; if (rev_tick !== 1'b0) begin n_fail++; $display("FAIL reset_rev_tick: got %0b want 0", rev_tick); end
    n_cmp++; if (rev_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_rev_cnt: got %0d want 0", rev_cnt); end
    n_cmp++; if (err_onehot !== 1'b0) begin n_fail++; $display("FAIL reset_err_onehot: got %0b want 0", err_onehot); end
    n_cmp++; if (err_seq !== 1'b0) begin n_fail++; $display("FAIL reset_err_seq: got %0b want 0", err_seq); end
    {q3, q2, q1, q0} = 4'b0000;
    clr = 1'b1;
    for (int i = 0; i < 5; i++) drive(4'b0000);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL idle_locked: got %0b want 0", locked); end
    n_cmp++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL idle_phase_valid: got %0b want 0", phase_valid); end
    n_cmp++; if ({err_onehot, err_seq} !== 2'b00) begin n_fail++; $display("FAIL idle_errors: got %b want 00", {err_onehot, err_seq}); end
  endtask

  task automatic test_lock;
    logic [3:0] seq [6]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] exp_ph [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_pv [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_lk [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      n_cmp++; if (phase !== exp_ph[i]) begin n_fail++; $display("FAIL lock_phase e%0d: got %0d want %0d", i + 1, phase, exp_ph[i]); end
      n_cmp++; if (phase_valid !== exp_pv[i]) begin n_fail++; $display("FAIL lock_phase_valid e%0d: got %0b want %0b", i + 1, phase_valid, exp_pv[i]); end
      n_cmp++; if (locked !== exp_lk[i]) begin n_fail++; $display("FAIL lock_locked e%0d: got %0b want %0b", i + 1, locked, exp_lk[i]); end
    end
    n_cmp++; if ({err_onehot, err_seq} !== 2'b00) begin n_fail++; $display("FAIL lock_errors: got %b want 00", {err_onehot, err_seq}); end
    n_cmp++; if (rev_cnt !== 8'd0) begin n_fail++; $display("FAIL lock_no_tick: rev_cnt got %0d want 0", rev_cnt); end
  endtask

  task automatic test_revolutions;
    int         pulses = 0;
    int         first_at = 0;
    int         second_at = 0;
    logic [3:0] hseq [5] = '{4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic       htick [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++) begin
      rotate(1);
      if (rev_tick === 1'b1) begin
        pulses++;
        if (pulses == 1) first_at = i; else second_at = i;
      end
    end
    n_cmp++; if (pulses !== 2) begin n_fail++; $display("FAIL rev_pulse_count: got %0d want 2", pulses); end
    n_cmp++; if (second_at - first_at !== 4) begin n_fail++; $display("FAIL rev_spacing: got %0d want 4", second_at - first_at); end
    n_cmp++; if (rev_cnt !== 8'd2) begin n_fail++; $display("FAIL rev_cnt_two: got %0d want 2", rev_cnt); end
    for (int i = 0; i < 5; i++) begin
      drive(hseq[i]);
      n_cmp++; if (rev_tick !== htick[i]) begin n_fail++; $display("FAIL hold_rev_tick c%0d: got %0b want %0b", i + 1, rev_tick, htick[i]); end
      n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL hold_locked c%0d: got %0b want 1", i + 1, locked); end
    end
    n_cmp++; if (rev_cnt !== 8'd3) begin n_fail++; $display("FAIL rev_cnt_three: got %0d want 3", rev_cnt); end
  endtask

  task automatic test_onehot_error;
    drive(4'b0101);
    n_cmp++; if (err_onehot !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL badhot_early: err_onehot=%0b locked=%0b want 0/1", err_onehot, locked); end
    drive(4'b0100);
    n_cmp++; if (err_onehot !== 1'b1) begin n_fail++; $display("FAIL badhot_flag: got %0b want 1", err_onehot); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL badhot_unlock: got %0b want 0", locked); end
    n_cmp++; if (err_seq !== 1'b0) begin n_fail++; $display("FAIL badhot_seq_clean: got %0b want 0", err_seq); end
    err_clr = 1'b1; drive(4'b1000); err_clr = 1'b0;
    n_cmp++; if (err_onehot !== 1'b0) begin n_fail++; $display("FAIL badhot_clear: got %0b want 0", err_onehot); end
    rotate(5);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL badhot_relock: got %0b want 1", locked); end
    drive(4'b0101);
    err_clr = 1'b1; drive(4'b0100); err_clr = 1'b0;
    n_cmp++; if (err_onehot !== 1'b1) begin n_fail++; $display("FAIL badhot_set_wins: got %0b want 1", err_onehot); end
    drive(4'b1000);
    n_cmp++; if (err_onehot !== 1'b1) begin n_fail++; $display("FAIL badhot_sticky: got %0b want 1", err_onehot); end
    err_clr = 1'b1; drive(4'b0001); err_clr = 1'b0;
    n_cmp++; if (err_onehot !== 1'b0) begin n_fail++; $display("FAIL badhot_clear2: got %0b want 0", err_onehot); end
  endtask

  task automatic test_seq_error;
    rotate(5);
    n_cmp++; if (locked !== 1'b1 || last !== 4'b0010) begin n_fail++; $display("FAIL seq_setup: locked=%0b q=%b want 1/0010", locked, last); end
    drive(4'b1000);
    drive(4'b0001);
    n_cmp++; if (err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_flag: got %0b want 1", err_seq); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL seq_unlock: got %0b want 0", locked); end
    n_cmp++; if (err_onehot !== 1'b0) begin n_fail++; $display("FAIL seq_onehot_clean: got %0b want 0", err_onehot); end
    rotate(3);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL seq_relock_early: got %0b want 0", locked); end
    rotate(1);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL seq_relock: got %0b want 1", locked); end
    n_cmp++; if (err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_sticky: got %0b want 1", err_seq); end
    err_clr = 1'b1; rotate(1); err_clr = 1'b0;
    n_cmp++; if (err_seq !== 1'b0) begin n_fail++; $display("FAIL seq_clear: got %0b want 0", err_seq); end
  endtask

  task automatic test_midop_reset_and_zero;
    #3 clr = 1'b0; {q3, q2, q1, q0} = 4'b0000;
    #1;
    n_cmp++; if (locked !== 1'b0 || rev_cnt !== 8'd0 || phase_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: locked=%0b rev_cnt=%0d phase_valid=%0b want 0/0/0", locked, rev_cnt, phase_valid);
    end
    @(posedge clk); #3 clr = 1'b1;
    drive(4'b0001);
    rotate(4);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL restart_early: got %0b want 0", locked); end
    rotate(1);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL restart_lock: got %0b want 1", locked); end
    rotate(4);
    n_cmp++; if (rev_tick !== 1'b1 || rev_cnt !== 8'd1) begin n_fail++; $display("FAIL restart_rev: tick=%0b rev_cnt=%0d want 1/1", rev_tick, rev_cnt); end
    drive(4'b0000);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL zero_early: got %0b want 1", locked); end
    drive(4'b0000);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL zero_unlock: got %0b want 0", locked); end
    n_cmp++; if ({err_onehot, err_seq} !== 2'b00) begin n_fail++; $display("FAIL zero_errors: got %b want 00", {err_onehot, err_seq}); end
    n_cmp++; if (rev_cnt !== 8'd1 || rev_cnt2 !== 2'd1) begin n_fail++; $display("FAIL zero_rev_kept: got %0d/%0d want 1/1", rev_cnt, rev_cnt2); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp8 [5] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    logic [1:0] exp2 [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    int         k = 0;
    drive(4'b0001);
    rotate(5);
    n_cmp++; if (locked2 !== 1'b1) begin n_fail++; $display("FAIL wrap_lock: got %0b want 1", locked2); end
    for (int i = 0; i < 24 && k < 5; i++) begin
      rotate(1);
      if (rev_tick2 === 1'b1) begin
        n_cmp++; if (rev_cnt2 !== exp2[k]) begin n_fail++; $display("FAIL wrap_cnt2 rev%0d: got %0d want %0d", k + 1, rev_cnt2, exp2[k]); end
        n_cmp++; if (rev_cnt !== exp8[k]) begin n_fail++; $display("FAIL wrap_cnt8 rev%0d: got %0d want %0d", k + 1, rev_cnt, exp8[k]); end
        k++;
      end
    end
    n_cmp++; if (k !== 5) begin n_fail++; $display("FAIL wrap_pulses: got %0d want 5", k); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_revolutions();
    test_onehot_error();
    test_seq_error();
    test_midop_reset_and_zero();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Downstream consumer of the 4-bit ring counter's one-hot outputs q0..q3. It samples the ring state every clock and decodes it to a 2-bit phase index. It checks one-hot integrity and rotation order (q0→q1→q2→q3→q0), locks after a run of legal advances, counts completed revolutions, and raises sticky error flags. Controllers that sequence off the ring counter phases use it to qualify those phases.

## Interface
- REV_W, 8, width of revolution counter rev_cnt
- LOCK_CNT, 4, consecutive legal advances required to enter LOCKED (1..15)
- clk  input  1  rising-edge clock, shared with the ring counter
- clr  input  1  asynchronous, active-low reset (clr=0 resets immediately, independent of clk)
- q0, q1, q2, q3  input  1 each  ring counter outputs; vector Q={q3,q2,q1,q0}
- err_clr  input  1  synchronous clear of sticky error flags
- phase  output  2  index of the hot bit of the sampled Q (q0→0 … q3→3); 0 when not one-hot
- phase_valid  output  1  sampled Q is exactly one-hot
- locked  output  1  monitor in LOCKED state
- rev_tick  output  1  one-cycle pulse per completed revolution (q3→q0 while LOCKED)
- rev_cnt  output  REV_W  revolution count
- err_onehot  output  1  sticky: non-one-hot, non-zero Q seen while LOCKED
- err_seq  output  1  sticky: one-hot Q that is neither hold nor rotation, seen while LOCKED

## Operation
- Input stage: S <= Q every edge; P <= S (previous sample). On reset both are 4'b0000.
- Classification of (P,S): ADV if S one-hot and S == rotl(P) (0001→0010→0100→1000→0001). HOLD if S one-hot and S == P. ZERO if S == 0000. BADHOT if S is non-zero and not one-hot. JUMP if S is one-hot and neither ADV nor HOLD.
- Lock counter lc has 4 bits.
- State HUNT (reset state):
  - ADV: lc+1; when lc+1 == LOCK_CNT go to LOCKED and set lc=0.
  - HOLD: lc unchanged.
  - ZERO, BADHOT, JUMP: lc=0.
  - No errors are flagged in HUNT.
- State LOCKED:
  - ADV or HOLD: stay. ADV with P=1000, S=0001 pulses rev_tick and increments rev_cnt.
  - ZERO: go to HUNT with no error (ring counter cleared or stopped).
  - BADHOT: set err_onehot and go to HUNT.
  - JUMP: set err_seq and go to HUNT.
- rev_tick fires only if the state is LOCKED when the pair is evaluated. The advance that completes locking never ticks.
- rev_cnt wraps modulo 2^REV_W. It is not cleared on unlock; only clr clears it.
- err_clr clears both sticky flags at the next edge. If a new error occurs in the same cycle as err_clr, the set wins and the flag stays 1.
- phase and phase_valid are registered decodes of S.

## Timing
- Every output resets to 0: phase, phase_valid, locked, rev_tick, rev_cnt, err_onehot, err_seq. State resets to HUNT, lc=0, S=P=0000.
- Latency, phase/phase_valid: Q sampled at edge k appears on phase/phase_valid after edge k+1.
- Latency, state-derived outputs: the (P,S) pair formed at edge k updates locked, rev_tick, rev_cnt and the error flags at edge k+1.
- Lock timing: with continuous rotation, locked rises at the (LOCK_CNT+1)-th edge after the edge that first samples a one-hot Q. With LOCK_CNT=4 that is the 5th edge.
- rev_tick: high for exactly one cycle. Spacing is 4 cycles at continuous rotation and longer if HOLD cycles intervene.
- Reset mid-operation: asserting clr clears all state asynchronously. After release, locking restarts from HUNT with lc=0.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold clr=0 with Q=0001 → all outputs 0. Release clr with Q=0000 for 5 cycles → locked=0, phase_valid=0, no errors.
- Lock: drive Q=0001 at edge e1, then rotate each cycle → locked=1 after e6, phase follows 0,1,2,3 lagging Q by 2 edges, err_onehot=err_seq=0.
- Revolutions: after lock, run 8 cycles of rotation → exactly 2 rev_tick pulses 4 cycles apart, rev_cnt=2. Insert one HOLD cycle → next pulse arrives 5 cycles after the previous one and locked stays 1.
- One-hot error: locked, force Q=0101 for one cycle → err_onehot=1 and locked=0 two edges later. Pulse err_clr → err_onehot=0 next edge. Repeat with err_clr coincident with a new BADHOT → err_onehot stays 1.
- Sequence error: locked at phase 1 (Q=0010), drive Q=1000 → err_seq=1, locked=0, err_onehot=0. Resume rotation → relock after LOCK_CNT advances, err_seq still 1.
- Cleared ring and wrap: locked, drive Q=0000 → locked=0, no error flags, rev_cnt retained. With REV_W=2, run 5 revolutions while locked → rev_cnt wraps 3→0→1.
